// File: rtl/cvp14_pkg.sv
// Shared definitions for the CVP14 vector datapath.
//   - opcode encodings (VADD..NOP)
//   - FP16 field constants
//   - sequencer state type for vec_alu_seq
package cvp14_pkg;

  localparam logic [3:0] OP_VADD = 4'd0;
  localparam logic [3:0] OP_VDOT = 4'd1;
  localparam logic [3:0] OP_SMUL = 4'd2;
  localparam logic [3:0] OP_SST  = 4'd3;
  localparam logic [3:0] OP_VLD  = 4'd4;
  localparam logic [3:0] OP_VST  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SLH  = 4'd7;
  localparam logic [3:0] OP_NOP  = 4'd15;

  localparam logic [4:0]  FP_EXP_MAX = 5'd31;
  localparam logic [4:0]  FP_BIAS    = 5'd15;
  localparam logic [15:0] FP_PINF    = 16'h7C00;
  localparam logic [15:0] FP_QNAN    = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp16_unit.sv
// Combinational FP16 add or multiply of one operand pair.
// Round toward zero, subnormals flushed to signed zero, exponent 31 = inf.
// Optional macro VALU_OVF_FLAG_EN adds o_ovf (finite inputs -> inf result).
// Ports:
//   i_a, i_b : FP16 operands
//   i_mul    : 1 = multiply, 0 = add
//   o_y      : FP16 result
//   o_ovf    : overflow indication (only with VALU_OVF_FLAG_EN)
module fp16_unit
  import cvp14_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_mul,
`ifdef VALU_OVF_FLAG_EN
  output logic        o_ovf,
`endif
  output logic [15:0] o_y
);

  // Exact sum of the aligned mantissas fits in 42 bits (max shift 29),
  // so truncation after normalisation gives correct round-toward-zero.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    logic              sh;
    logic [4:0]        ea, eb, eh, el, d;
    logic [10:0]       mh, ml;
    logic [41:0]       s, n;
    logic [5:0]        p;
    logic signed [7:0] er;
    ea = a[14:10];
    eb = b[14:10];
    if (ea == FP_EXP_MAX && eb == FP_EXP_MAX)
      return (a[15] != b[15]) ? FP_QNAN : (FP_PINF | {a[15], 15'd0});
    if (ea == FP_EXP_MAX) return FP_PINF | {a[15], 15'd0};
    if (eb == FP_EXP_MAX) return FP_PINF | {b[15], 15'd0};
    if (ea == 5'd0 && eb == 5'd0) return 16'h0000;
    if (ea == 5'd0) return b;
    if (eb == 5'd0) return a;
    if (a[14:0] >= b[14:0]) begin
      sh = a[15]; eh = ea; el = eb; mh = {1'b1, a[9:0]}; ml = {1'b1, b[9:0]};
    end else begin
      sh = b[15]; eh = eb; el = ea; mh = {1'b1, b[9:0]}; ml = {1'b1, a[9:0]};
    end
    d = eh - el;
    s = {31'd0, mh} << d;
    if (a[15] == b[15]) s = s + {31'd0, ml};
    else                s = s - {31'd0, ml};
    if (s == '0) return 16'h0000;
    p = '0;
    for (int unsigned i = 0; i < 42; i++)
      if (s[i]) p = 6'(i);
    n  = s << (6'd41 - p);
    er = 8'(el) + 8'(p) - 8'd10;
    if (er >= 8'sd31) return FP_PINF | {sh, 15'd0};
    if (er <= 8'sd0)  return {sh, 15'd0};
    return {sh, er[4:0], n[40:31]};
  endfunction

  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic              sg;
    logic [4:0]        ea, eb;
    logic [21:0]       prod;
    logic [9:0]        mant;
    logic signed [7:0] er;
    sg = a[15] ^ b[15];
    ea = a[14:10];
    eb = b[14:10];
    if (ea == FP_EXP_MAX || eb == FP_EXP_MAX)
      return (ea == 5'd0 || eb == 5'd0) ? FP_QNAN : (FP_PINF | {sg, 15'd0});
    if (ea == 5'd0 || eb == 5'd0) return {sg, 15'd0};
    prod = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    mant = prod[21] ? prod[20:11] : prod[19:10];
    er   = 8'(ea) + 8'(eb) - 8'(FP_BIAS) + 8'(prod[21]);
    if (er >= 8'sd31) return FP_PINF | {sg, 15'd0};
    if (er <= 8'sd0)  return {sg, 15'd0};
    return {sg, er[4:0], mant};
  endfunction

  assign o_y = i_mul ? fmul(i_a, i_b) : fadd(i_a, i_b);

`ifdef VALU_OVF_FLAG_EN
  // With finite inputs an infinite result can only come from overflow.
  assign o_ovf = (o_y[14:0] == FP_PINF[14:0]) &&
                 (i_a[14:10] != FP_EXP_MAX) && (i_b[14:10] != FP_EXP_MAX);
`endif

endmodule

// File: rtl/vec_alu_seq.sv
// Multi-cycle FP16 vector ALU with valid/ready handshakes on both sides.
// Vector ops (VADD, VDOT, SMUL) run LANES/LPC EXEC cycles through LPC
// shared fp16_unit lanes; scalar ops finish in the cycle after acceptance.
// Optional macro VALU_OVF_FLAG_EN adds out_ovf (sticky FP overflow flag).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : request handshake
//   in_opcode             : operation select
//   in_op1, in_op2        : operands (vector or scalar in low bits)
//   out_valid / out_ready : result handshake
//   out_result            : result vector
//   out_ovf               : overflow flag (only with VALU_OVF_FLAG_EN)
module vec_alu_seq
  import cvp14_pkg::*;
#(
  parameter int LANES = 16,
  parameter int LPC   = 4,
  parameter int OPW   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPW-1:0]        in_opcode,
  input  logic [16*LANES-1:0]   in_op1,
  input  logic [16*LANES-1:0]   in_op2,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef VALU_OVF_FLAG_EN
  output logic                  out_ovf,
`endif
  output logic [16*LANES-1:0]   out_result
);

  localparam int W  = 16 * LANES;
  localparam int GW = 16 * LPC;
  localparam int NG = LANES / LPC;
  localparam int KW = (NG > 1) ? $clog2(NG) : 1;

  state_t           r_state;
  logic [OPW-1:0]   r_op;
  logic [W-1:0]     r_op1, r_op2, r_result;
  logic [15:0]      r_scal, r_acc;
  logic [KW-1:0]    r_k;

  logic             w_vec_in, w_vdot, w_smul, w_mul_mode, w_last;
  logic [W-1:0]     w_scalar;
  logic [15:0]      w_lane [LPC];
  logic [15:0]      w_acc  [LPC+1];
  logic [GW-1:0]    w_grp;

  assign w_vec_in   = (in_opcode == OPW'(OP_VADD)) || (in_opcode == OPW'(OP_VDOT)) ||
                      (in_opcode == OPW'(OP_SMUL));
  assign w_vdot     = (r_op == OPW'(OP_VDOT));
  assign w_smul     = (r_op == OPW'(OP_SMUL));
  assign w_mul_mode = w_vdot | w_smul;
  assign w_last     = (r_k == KW'(NG - 1));

  always_comb begin
    w_scalar = '0;
    case (in_opcode)
      OPW'(OP_VLD), OPW'(OP_VST): w_scalar[15:0] = in_op1[15:0] + in_op2[15:0];
      OPW'(OP_SLL):               w_scalar[15:0] = {in_op1[15:8], in_op2[7:0]};
      OPW'(OP_SLH):               w_scalar[15:0] = {in_op2[7:0], in_op1[7:0]};
      OPW'(OP_SST), OPW'(OP_NOP): w_scalar = '0;
      default:                    w_scalar = '0;
    endcase
  end

  // Operand registers shift down one group per EXEC cycle, so the lane
  // units always read the low GW bits; results shift in from the top.
  assign w_acc[0] = r_acc;

`ifdef VALU_OVF_FLAG_EN
  logic [LPC-1:0] w_lane_ovf, w_chain_ovf;
  logic           w_grp_ovf;
  logic           r_ovf;
  assign w_grp_ovf = (|w_lane_ovf) | (w_vdot & (|w_chain_ovf));
  assign out_ovf   = r_ovf;
`endif

  for (genvar g = 0; g < LPC; g++) begin : g_lane
    fp16_unit u_lane (
      .i_a   (w_smul ? r_scal : r_op1[16*g +: 16]),
      .i_b   (r_op2[16*g +: 16]),
      .i_mul (w_mul_mode),
`ifdef VALU_OVF_FLAG_EN
      .o_ovf (w_lane_ovf[g]),
`endif
      .o_y   (w_lane[g])
    );

    // VDOT fold: ascending lane order, chained within the group.
    fp16_unit u_chain (
      .i_a   (w_acc[g]),
      .i_b   (w_lane[g]),
      .i_mul (1'b0),
`ifdef VALU_OVF_FLAG_EN
      .o_ovf (w_chain_ovf[g]),
`endif
      .o_y   (w_acc[g+1])
    );

    assign w_grp[16*g +: 16] = w_lane[g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
      r_scal   <= '0;
      r_acc    <= '0;
      r_k      <= '0;
`ifdef VALU_OVF_FLAG_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op   <= in_opcode;
            r_op1  <= in_op1;
            r_op2  <= in_op2;
            r_scal <= in_op1[15:0];
            r_acc  <= '0;
            r_k    <= '0;
`ifdef VALU_OVF_FLAG_EN
            r_ovf  <= 1'b0;
`endif
            if (w_vec_in) begin
              r_result <= '0;
              r_state  <= ST_EXEC;
            end else begin
              r_result <= w_scalar;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          r_op1 <= r_op1 >> GW;
          r_op2 <= r_op2 >> GW;
          r_acc <= w_acc[LPC];
          r_k   <= r_k + KW'(1);
          if (w_vdot) begin
            if (w_last) r_result <= W'(w_acc[LPC]);
          end else begin
            r_result <= (r_result >> GW) | (W'(w_grp) << (W - GW));
          end
`ifdef VALU_OVF_FLAG_EN
          r_ovf <= r_ovf | w_grp_ovf;
`endif
          if (w_last) begin
            r_k     <= '0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;

endmodule

// File: tb/tb_vec_alu_seq.sv
module tb_vec_alu_seq;
  localparam int LANES = 16;
  localparam int LPC   = 4;
  localparam int OPW   = 4;
  localparam int W     = 16 * LANES;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, out_valid, out_ready;
  logic [OPW-1:0] in_opcode;
  logic [W-1:0]   in_op1, in_op2, out_result;
`ifdef VALU_OVF_FLAG_EN
  logic           out_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vec_alu_seq #(.LANES(LANES), .LPC(LPC), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef VALU_OVF_FLAG_EN
    .out_ovf    (out_ovf),
`endif
    .out_result (out_result)
  );

  // Issue one request from IDLE and wait (bounded) for out_valid.
  // lat = cycles from the accepting edge until out_valid, 0 on timeout.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_op1 = a; in_op2 = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = 0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_tests++;
    if (out_result !== '0) begin n_fail++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
`ifdef VALU_OVF_FLAG_EN
    n_tests++;
    if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", out_ovf); end
`endif
  endtask

  task automatic test_vadd();
    int lat;
    logic [W-1:0] a, b, e;
    do_op(4'd0, {LANES{16'h3C00}}, {LANES{16'h4000}}, lat);
    n_tests++;
    if (lat != 5) begin n_fail++; $display("FAIL vadd_latency: got %0d expected 5", lat); end
    n_tests++;
    if (out_result !== {LANES{16'h4200}}) begin
      n_fail++; $display("FAIL vadd_basic: got %h expected %h", out_result, {LANES{16'h4200}});
    end
`ifdef VALU_OVF_FLAG_EN
    n_tests++;
    if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL vadd_basic_ovf: got %b expected 0", out_ovf); end
`endif
    release_out();

    // Boundary lanes: RTZ up/down, inf-inf, exact zero, subnormal, overflow.
    a = '0; b = '0; e = '0;
    a[0*16 +: 16] = 16'h3C00; b[0*16 +: 16] = 16'h1200; e[0*16 +: 16] = 16'h3C00;
    a[1*16 +: 16] = 16'h3C00; b[1*16 +: 16] = 16'h9200; e[1*16 +: 16] = 16'h3BFE;
    a[2*16 +: 16] = 16'h7C00; b[2*16 +: 16] = 16'hFC00; e[2*16 +: 16] = 16'h7E00;
    a[3*16 +: 16] = 16'h3C00; b[3*16 +: 16] = 16'hBC00; e[3*16 +: 16] = 16'h0000;
    a[4*16 +: 16] = 16'h0001; b[4*16 +: 16] = 16'h0000; e[4*16 +: 16] = 16'h0000;
    a[5*16 +: 16] = 16'h7BFF; b[5*16 +: 16] = 16'h7BFF; e[5*16 +: 16] = 16'h7C00;
    a[6*16 +: 16] = 16'h3C00; b[6*16 +: 16] = 16'h0000; e[6*16 +: 16] = 16'h3C00;
    do_op(4'd0, a, b, lat);
    n_tests++;
    if (out_result !== e) begin n_fail++; $display("FAIL vadd_edges: got %h expected %h", out_result, e); end
`ifdef VALU_OVF_FLAG_EN
    n_tests++;
    if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL vadd_edges_ovf: got %b expected 1", out_ovf); end
`endif
    release_out();
  endtask

  task automatic test_vdot();
    int lat;
    logic [W-1:0] e;
    e = '0; e[15:0] = 16'h5000;
    do_op(4'd1, {LANES{16'h3C00}}, {LANES{16'h4000}}, lat);
    n_tests++;
    if (lat != 5) begin n_fail++; $display("FAIL vdot_latency: got %0d expected 5", lat); end
    n_tests++;
    if (out_result !== e) begin n_fail++; $display("FAIL vdot_sum: got %h expected %h", out_result, e); end
`ifdef VALU_OVF_FLAG_EN
    n_tests++;
    if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL vdot_sum_ovf: got %b expected 0", out_ovf); end
`endif
    release_out();

    e = '0; e[15:0] = 16'h7C00;
    do_op(4'd1, W'(16'h7BFF), W'(16'h7BFF), lat);
    n_tests++;
    if (out_result !== e) begin n_fail++; $display("FAIL vdot_overflow: got %h expected %h", out_result, e); end
`ifdef VALU_OVF_FLAG_EN
    n_tests++;
    if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL vdot_overflow_ovf: got %b expected 1", out_ovf); end
`endif
    release_out();
  endtask

  task automatic test_smul();
    int lat;
    do_op(4'd2, {{(LANES-1){16'h5555}}, 16'h4000}, {LANES{16'h3E00}}, lat);
    n_tests++;
    if (out_result !== {LANES{16'h4200}}) begin
      n_fail++; $display("FAIL smul: got %h expected %h", out_result, {LANES{16'h4200}});
    end
    release_out();
  endtask

  task automatic test_scalar();
    int lat;
    logic [W-1:0] a, b;
    a = {{(LANES-1){16'hFFFF}}, 16'h1234};
    b = {{(LANES-1){16'hFFFF}}, 16'hCDAB};
    do_op(4'd6, a, b, lat);
    n_tests++;
    if (lat != 1) begin n_fail++; $display("FAIL sll_latency: got %0d expected 1", lat); end
    n_tests++;
    if (out_result !== W'(16'h12AB)) begin n_fail++; $display("FAIL sll: got %h expected 12ab", out_result); end
    release_out();
    do_op(4'd7, a, b, lat);
    n_tests++;
    if (out_result !== W'(16'hAB34)) begin n_fail++; $display("FAIL slh: got %h expected ab34", out_result); end
    release_out();
    do_op(4'd4, W'(16'hFFFF), W'(16'h0002), lat);
    n_tests++;
    if (out_result !== W'(16'h0001)) begin n_fail++; $display("FAIL vld_wrap: got %h expected 0001", out_result); end
    release_out();
    do_op(4'd5, W'(16'h1000), W'(16'h0234), lat);
    n_tests++;
    if (out_result !== W'(16'h1234)) begin n_fail++; $display("FAIL vst_add: got %h expected 1234", out_result); end
    release_out();
    do_op(4'hC, a, b, lat);
    n_tests++;
    if (lat != 1) begin n_fail++; $display("FAIL undef_latency: got %0d expected 1", lat); end
    n_tests++;
    if (out_result !== '0) begin n_fail++; $display("FAIL undef_op: got %h expected 0", out_result); end
    release_out();
    do_op(4'd3, a, b, lat);
    n_tests++;
    if (out_result !== '0) begin n_fail++; $display("FAIL sst_op: got %h expected 0", out_result); end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(4'd0, {LANES{16'h3C00}}, {LANES{16'h4000}}, lat);
    in_valid = 1'b1; in_opcode = 4'd6;
    in_op1 = W'(16'h1234); in_op2 = W'(16'h00AB);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== {LANES{16'h4200}}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b result=%h expected valid=1 ready=0 result=%h",
                 i, out_valid, in_ready, out_result, {LANES{16'h4200}});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_result !== W'(16'h12AB)) begin
      n_fail++; $display("FAIL bp_accept_after: got valid=%b result=%h expected valid=1 result=12ab",
                         out_valid, out_result);
    end
    release_out();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic [W-1:0] e;
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 4'd0;
    in_op1 = {LANES{16'h3C00}}; in_op2 = {LANES{16'h4000}};
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== '0) begin
      n_fail++; $display("FAIL midop_reset: got valid=%b ready=%b result=%h expected valid=0 ready=1 result=0",
                         out_valid, in_ready, out_result);
    end
    rst_n = 1'b1;
    e = '0; e[15:0] = 16'h5000;
    do_op(4'd1, {LANES{16'h3C00}}, {LANES{16'h4000}}, lat);
    n_tests++;
    if (out_result !== e) begin n_fail++; $display("FAIL midop_vdot_after: got %h expected %h", out_result, e); end
    release_out();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_op1 = '0; in_op2 = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_vadd();
    test_vdot();
    test_smul();
    test_scalar();
    test_backpressure();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
